// File: rtl/imem_pkg.sv
// Shared types, constants and the address check for the instruction-memory port arbiter.
package imem_pkg;

  typedef enum logic {PORT_F = 1'b0, PORT_D = 1'b1} port_e;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RESP = 1'b1;

  // Returned on error responses: "j Normal".
  localparam logic [31:0] IMEM_DEFAULT_INSTR = 32'h0800_0003;

  // Word-aligned and inside the 2**addr_w word store.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (addr_w + 2)) - 32'd1);
    return (addr[1:0] == 2'b00) && ((addr & hi_mask) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_grant_sel.sv
// Fetch-priority grant with a starvation counter that eventually forces the debug port in.
module imem_grant_sel
  import imem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic f_valid,
  input  logic f_elig,
  input  logic d_valid,
  input  logic d_elig,
  output logic gnt_f,
  output logic gnt_d
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            f_cand, d_cand, starved;

  assign f_cand  = f_valid & f_elig;
  assign d_cand  = d_valid & d_elig;
  assign starved = (cnt_q == CntW'(STARVE_LIMIT));

  assign gnt_d = d_cand & (~f_cand | starved);
  // F holds the grant whenever D does not take it, so an idle F sees ready early.
  assign gnt_f = f_elig & ~gnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!d_cand || gnt_d) begin
      cnt_d = '0;
    end else if (f_cand) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one instruction-store port between the fetch stage (F) and the debug/loader port (D).
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W        = 5,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter logic [31:0] DEFAULT_INSTR = IMEM_DEFAULT_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  output logic              f_req_ready,
  input  logic [31:0]       f_req_addr,
  output logic              f_rsp_valid,
  input  logic              f_rsp_ready,
  output logic [31:0]       f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [31:0]       d_req_addr,
  input  logic              d_req_wen,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic        f_st_q, f_st_d, d_st_q, d_st_d;
  logic [31:0] f_data_q, f_data_d, d_data_q, d_data_d;
  logic        f_err_q, f_err_d, d_err_q, d_err_d;
  logic        gnt_f, gnt_d, f_acc, d_acc, f_ok, d_ok;

  imem_grant_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_sel (
    .clk     (clk),
    .reset   (reset),
    .f_valid (f_req_valid),
    .f_elig  (f_st_q == ST_IDLE),
    .d_valid (d_req_valid),
    .d_elig  (d_st_q == ST_IDLE),
    .gnt_f   (gnt_f),
    .gnt_d   (gnt_d)
  );

  // No request is accepted while reset is held.
  assign f_req_ready = reset & gnt_f;
  assign d_req_ready = reset & gnt_d;
  assign f_acc       = f_req_valid & f_req_ready;
  assign d_acc       = d_req_valid & d_req_ready;
  assign f_ok        = addr_ok(f_req_addr, ADDR_W);
  assign d_ok        = addr_ok(d_req_addr, ADDR_W);

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    if (d_acc && d_ok) begin
      mem_addr  = d_req_addr[ADDR_W+1:2];
      mem_wen   = d_req_wen;
      mem_wdata = d_req_wen ? d_req_wdata : '0;
    end else if (f_acc && f_ok) begin
      mem_addr = f_req_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    f_st_d   = f_st_q;
    f_data_d = f_data_q;
    f_err_d  = f_err_q;
    unique case (f_st_q)
      ST_IDLE: begin
        if (f_acc) begin
          f_st_d   = ST_RESP;
          f_err_d  = ~f_ok;
          f_data_d = f_ok ? mem_rdata : DEFAULT_INSTR;
        end
      end
      ST_RESP: begin
        if (f_rsp_ready) f_st_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    d_st_d   = d_st_q;
    d_data_d = d_data_q;
    d_err_d  = d_err_q;
    unique case (d_st_q)
      ST_IDLE: begin
        if (d_acc) begin
          d_st_d   = ST_RESP;
          d_err_d  = ~d_ok;
          d_data_d = d_req_wen ? '0 : (d_ok ? mem_rdata : DEFAULT_INSTR);
        end
      end
      ST_RESP: begin
        if (d_rsp_ready) d_st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_st_q   <= ST_IDLE;
      f_data_q <= '0;
      f_err_q  <= 1'b0;
      d_st_q   <= ST_IDLE;
      d_data_q <= '0;
      d_err_q  <= 1'b0;
    end else begin
      f_st_q   <= f_st_d;
      f_data_q <= f_data_d;
      f_err_q  <= f_err_d;
      d_st_q   <= d_st_d;
      d_data_q <= d_data_d;
      d_err_q  <= d_err_d;
    end
  end

  assign f_rsp_valid = (f_st_q == ST_RESP);
  assign f_rsp_data  = f_data_q;
  assign f_rsp_err   = f_err_q;
  assign d_rsp_valid = (d_st_q == ST_RESP);
  assign d_rsp_data  = d_data_q;
  assign d_rsp_err   = d_err_q;

endmodule
